// File: rtl/alu_mc.sv
// Clocked 8-op ALU with valid/ready handshakes, a single-entry output register
// and an iterative restoring divider (one quotient bit per cycle).
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | accepting requests; non-divide ops complete at the accept edge
// S_DIV  | shift-subtract divide in progress, input and output both closed
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           op,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   alu_out,
  output logic                 div_by_zero,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DIV  = 1'b1;
  localparam int         CW     = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_NA  = 3'b110;
  localparam logic [2:0] OP_NB  = 3'b111;

  logic [0:0]         state_q,     state_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] alu_out_q,   alu_out_d;
  logic               dbz_q,       dbz_d;
  logic [WIDTH-1:0]   rem_q,       rem_d;
  logic [WIDTH-1:0]   quo_q,       quo_d;
  logic [WIDTH-1:0]   dvs_q,       dvs_d;
  logic [CW-1:0]      cnt_q,       cnt_d;

  logic [2*WIDTH-1:0] a_ext, b_ext, fast_res;
  logic               accept, start_div, fast_done, xfer;
  logic [WIDTH:0]     trial, diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;

  assign in_ready = rst_n & (state_q == S_IDLE) & (~out_valid_q | out_ready);

  always_comb begin
    a_ext = {{WIDTH{1'b0}}, A};
    b_ext = {{WIDTH{1'b0}}, B};
    fast_res = '0;
    case (op)
      OP_ADD:  fast_res = a_ext + b_ext;
      OP_SUB:  fast_res = a_ext - b_ext;
      OP_MUL:  fast_res = a_ext * b_ext;
      // only reached with B == 0; nonzero divisors go through S_DIV
      OP_DIV:  fast_res = {A, {WIDTH{1'b1}}};
      OP_OR:   fast_res = a_ext | b_ext;
      OP_AND:  fast_res = a_ext & b_ext;
      OP_NA:   fast_res = ~a_ext;
      OP_NB:   fast_res = ~b_ext;
      default: fast_res = '0;
    endcase
  end

  // Restoring step: trial < 2*divisor, so the borrow bit alone decides the quotient bit.
  always_comb begin
    trial   = {rem_q, quo_q[WIDTH-1]};
    diff    = trial - {1'b0, dvs_q};
    ge      = ~diff[WIDTH];
    rem_nxt = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ge};
  end

  always_comb begin
    accept    = in_valid & in_ready;
    start_div = accept & (op == OP_DIV) & (B != '0);
    fast_done = accept & ~start_div;
    xfer      = out_valid_q & out_ready;

    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    dbz_d       = dbz_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;

    if (xfer) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fast_done) begin
          alu_out_d   = fast_res;
          dbz_d       = (op == OP_DIV);
          out_valid_d = 1'b1;
        end else if (start_div) begin
          rem_d   = '0;
          quo_d   = A;
          dvs_d   = B;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          alu_out_d   = {rem_nxt, quo_nxt};
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      dbz_q       <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      dbz_q       <= dbz_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
    end
  end

  assign alu_out     = alu_out_q;
  assign div_by_zero = dbz_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=16): driver pushes hand-computed results,
// a negedge monitor pops and compares on every output transfer.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [2:0]  op = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_out;
  logic        div_by_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;

  alu_mc #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .op(op),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .div_by_zero(div_by_zero),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%08h expected none at %0t", alu_out, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", alu_out, e.res);
        chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input logic dbz, input bit push);
    int n;
    exp_t e;
    op = o; A = a; B = b; in_valid = 1'b1;
    if (push) begin
      e.res = exp; e.dbz = dbz;
      sb.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op %0d not accepted after %0d cycles", o, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = $urandom_range(7, 0);
    A = 16'($urandom);
    B = 16'($urandom);
  endtask

  task automatic wait_valid(output int n, output int low);
    n = 0;
    low = 0;
    do begin
      @(negedge clk);
      n++;
      if (!in_ready) low++;
    end while (!out_valid && n < 100);
  endtask

  initial begin
    int n, low;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
    step();

    issue(3'b000, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0, 1'b1);
    wait_valid(n, low);
    chk("add_latency", n, 32'd1);
    step();

    // back-to-back non-divide ops
    issue(3'b001, 16'h0003, 16'h0005, 32'hFFFF_FFFE, 1'b0, 1'b1);
    issue(3'b110, 16'h00F0, 16'h1111, 32'hFFFF_FF0F, 1'b0, 1'b1);
    issue(3'b100, 16'h0F0F, 16'h00FF, 32'h0000_0FFF, 1'b0, 1'b1);
    issue(3'b101, 16'h0F0F, 16'h00FF, 32'h0000_000F, 1'b0, 1'b1);
    issue(3'b111, 16'h5555, 16'h1234, 32'hFFFF_EDCB, 1'b0, 1'b1);
    issue(3'b010, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1'b1);
    issue(3'b000, 16'h1234, 16'h4321, 32'h0000_5555, 1'b0, 1'b1);
    repeat (3) step();

    issue(3'b011, 16'd100, 16'd7, 32'h0002_000E, 1'b0, 1'b1);
    wait_valid(n, low);
    chk("div_latency", n, 32'd17);
    chk("div_in_ready_low", low, 32'd16);
    step();

    issue(3'b011, 16'h0005, 16'h0000, 32'h0005_FFFF, 1'b1, 1'b1);
    wait_valid(n, low);
    chk("dbz_latency", n, 32'd1);
    step();
    issue(3'b000, 16'h0005, 16'h0006, 32'h0000_000B, 1'b0, 1'b1);

    issue(3'b011, 16'hFFFF, 16'h0001, 32'h0000_FFFF, 1'b0, 1'b1);
    issue(3'b011, 16'h0007, 16'h0064, 32'h0007_0000, 1'b0, 1'b1);
    issue(3'b011, 16'hFFFF, 16'h00FF, 32'h0000_0101, 1'b0, 1'b1);
    repeat (25) step();

    // backpressure
    out_ready = 1'b0;
    issue(3'b010, 16'h1234, 16'h0010, 32'h0001_2340, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_alu_out", alu_out, 32'h0001_2340);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    step();
    out_ready = 1'b1;
    issue(3'b000, 16'h0001, 16'h0001, 32'h0000_0002, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp_reload_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_reload_out", alu_out, 32'h0000_0002);
    step();

    // reset during a divide
    issue(3'b011, 16'hFFFF, 16'h0003, 32'h0000_0000, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_alu_out", alu_out, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    issue(3'b000, 16'h0002, 16'h0002, 32'h0000_0004, 1'b0, 1'b1);
    repeat (25) step();

    for (int i = 0; i < 100 && sb.size() != 0; i++) step();
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
